stream_fifo_monitor: RTL and testbench

- Passive observer at the far end of a StreamingFIFO's status and handshake pins.
- The FIFO produces count/maxcount and the two AXI-Stream handshakes; this block consumes them.
- It accumulates occupancy and stall statistics, and cross-checks count against its own beat tracking.
- Results go out through a simple request/acknowledge read port, used for FIFO depth sizing on hardware.

---
 rtl/fifo_mon_pkg.sv | 15 +
 rtl/stream_fifo_monitor_sat_counter.sv | 14 +
 rtl/stream_fifo_monitor.sv | 92 +++++++++
 tb/tb_stream_fifo_monitor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_mon_pkg.sv
// fifo_mon_pkg: shared state encoding, read address map and status-word layout for stream_fifo_monitor.
package fifo_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_t;
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_PEAK   = 3'd1;
  localparam logic [2:0] A_MF     = 3'd2;
  localparam logic [2:0] A_BIN    = 3'd3;
  localparam logic [2:0] A_BOUT   = 3'd4;
  localparam logic [2:0] A_FULL   = 3'd5;
  localparam logic [2:0] A_STALL  = 3'd6;
  localparam logic [2:0] A_STARVE = 3'd7;
  localparam int ST_ERR   = 0;
  localparam int ST_STATE = 1;
  localparam int ST_W     = 3;
endpackage

// File: rtl/stream_fifo_monitor_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en && q != '1) q <= q + W'(1);
endmodule

// File: rtl/stream_fifo_monitor.sv
// stream_fifo_monitor: passive StreamingFIFO observer collecting occupancy/stall statistics
// and cross-checking the reported count against its own beat tracking.
module stream_fifo_monitor
  import fifo_mon_pkg::*;
#(
  parameter int CNT_W  = 9,
  parameter int DEPTH  = 400,
  parameter int STAT_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  maxcount,
  input  logic              in_tvalid,
  input  logic              in_tready,
  input  logic              out_tvalid,
  input  logic              out_tready,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [2:0]        rd_addr,
  output logic              rd_ack,
  output logic [STAT_W-1:0] rd_data,
  output logic              err
);
  state_t state, state_nx;
  logic [CNT_W-1:0] shadow, shadow_nx, peak, mf_snap;
  logic [ST_W-1:0] status;
  logic [A_STARVE:A_BIN] inc;
  logic [STAT_W-1:0] word [8];
  logic in_fire, out_fire, run, entry;
  assign in_fire  = in_tvalid & in_tready;
  assign out_fire = out_tvalid & out_tready;
  assign run      = state == RUN;
  assign entry    = state_nx == RUN && !run;
  always_ff @(posedge ap_clk)
    if (ap_rst) state <= IDLE;
    else state <= state_nx;
  // clear beats start, start beats stop; stop only matters while running
  always_comb begin
    state_nx = state;
    state_nx = clear ? IDLE : start ? RUN : (stop && run) ? FROZEN : state;
  end
  always_comb begin
    shadow_nx = shadow;
    shadow_nx = (in_fire && !out_fire && shadow != CNT_W'(DEPTH)) ? shadow + CNT_W'(1)
              : (out_fire && !in_fire && shadow != '0) ? shadow - CNT_W'(1) : shadow;
  end
  always_ff @(posedge ap_clk)
    if (ap_rst || clear) begin
      shadow  <= '0;
      peak    <= '0;
      mf_snap <= '0;
      err     <= 1'b0;
    end else if (entry) begin
      shadow <= count;
    end else if (run) begin
      shadow  <= shadow_nx;
      peak    <= count > peak ? count : peak;
      mf_snap <= maxcount;
      err     <= err | (count != shadow);
    end
  assign inc[A_BIN]    = in_fire;
  assign inc[A_BOUT]   = out_fire;
  assign inc[A_FULL]   = count == CNT_W'(DEPTH);
  assign inc[A_STALL]  = in_tvalid & ~in_tready;
  assign inc[A_STARVE] = out_tready & ~out_tvalid;
  genvar i;
  for (i = A_BIN; i <= A_STARVE; i++) begin : g_cnt
    sat_counter #(.W(STAT_W)) u_cnt (
      .clk(ap_clk),
      .rst(ap_rst),
      .clr(clear),
      .en (run & inc[i]),
      .q  (word[i])
    );
  end
  assign status[ST_ERR]        = err;
  assign status[ST_STATE +: 2] = state;
  assign word[A_STATUS] = STAT_W'(status);
  assign word[A_PEAK]   = STAT_W'(peak);
  assign word[A_MF]     = STAT_W'(mf_snap);
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= word[rd_addr];
    end
endmodule

// File: tb/tb_stream_fifo_monitor.sv
// tb_stream_fifo_monitor: directed stimulus with a read scoreboard; a narrow-counter twin
// instance sees the same traffic so counter saturation is reachable in a short run.
module tb_stream_fifo_monitor;
  logic ap_clk = 0, ap_rst = 1;
  logic [8:0] count = 0, maxcount = 9'd123;
  logic in_tvalid = 0, in_tready = 0, out_tvalid = 0, out_tready = 0;
  logic start = 0, stop = 0, clear = 0, rd_req = 0;
  logic [2:0] rd_addr = 0;
  logic rd_ack, err, rd_ack_s, err_s;
  logic [31:0] rd_data;
  logic [3:0] rd_data_s;
  int checks = 0, failures = 0, cnt = 0;
  logic exp_ack = 0;

  typedef struct {
    logic [31:0] d;
    logic        care_s;
    logic [3:0]  ds;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 ap_clk = ~ap_clk;

  stream_fifo_monitor dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .count(count), .maxcount(maxcount),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .start(start), .stop(stop), .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .err(err)
  );

  stream_fifo_monitor #(.STAT_W(4)) dut_s (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .count(count), .maxcount(maxcount),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .start(start), .stop(stop), .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack_s), .rd_data(rd_data_s), .err(err_s)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // One clock of stimulus; cnt models the FIFO occupancy driven onto count.
  task automatic step(input logic iv = 0, input logic ir = 0, input logic ov = 0, input logic orr = 0);
    in_tvalid = iv; in_tready = ir; out_tvalid = ov; out_tready = orr;
    count = 9'(cnt);
    @(posedge ap_clk); #1;
    if (iv && ir && !(ov && orr) && cnt < 400) cnt++;
    else if (ov && orr && !(iv && ir) && cnt > 0) cnt--;
    start = 0; stop = 0; clear = 0; rd_req = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] d, input string n,
                    input logic cs = 0, input logic [3:0] ds = 0);
    rd_req = 1; rd_addr = a;
    sb.push_back('{d, cs, ds, n});
    step();
  endtask

  always @(posedge ap_clk) exp_ack <= rd_req & ~ap_rst;

  always @(negedge ap_clk) begin
    if (rd_ack || exp_ack) chk("rd_ack_timing", 32'(rd_ack), 32'(exp_ack));
    if (rd_ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'(rd_ack), 32'd0);
      else begin
        e = sb.pop_front();
        chk(e.name, rd_data, e.d);
        if (e.care_s) chk({e.name, "_narrow"}, 32'(rd_data_s), 32'(e.ds));
      end
    end
  end

  initial begin
    repeat (2) step();
    ap_rst = 0;
    step();
    chk("reset_err", 32'(err), 0);
    for (int a = 0; a < 8; a++) rd(3'(a), 0, $sformatf("reset_addr%0d", a));
    // 6 input fires, then 4 cycles firing both sides: 10 in, 4 out, occupancy peaks at 6
    start = 1; step();
    repeat (6) step(1, 1, 0, 0);
    repeat (4) step(1, 1, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    rd(3, 10, "beats_in");
    rd(4, 4, "beats_out");
    rd(1, 6, "peak");
    rd(2, 123, "mf_snap");
    rd(7, 3, "out_starve");
    rd(6, 0, "in_stall_none");
    rd(0, 2, "status_run");
    chk("err_tracking", 32'(err), 0);
    // full for 25 RUN cycles, stop on the last of them
    cnt = 400; clear = 1; step();
    start = 1; step();
    for (int k = 0; k < 25; k++) begin
      stop = (k == 24);
      step(1, 0, 0, 0);
    end
    rd(5, 25, "full_cyc");
    rd(6, 25, "in_stall");
    rd(1, 400, "peak_full");
    rd(0, 4, "status_frozen");
    chk("err_full", 32'(err), 0);
    // output fire at empty: shadow must hold at 0
    cnt = 0; clear = 1; step();
    start = 1; step();
    step(0, 0, 1, 1);
    step();
    chk("shadow_floor", 32'(err), 0);
    rd(4, 1, "beats_out_empty");
    // mismatch injection
    cnt = 5; clear = 1; step();
    start = 1; step();
    step();
    chk("err_before_inject", 32'(err), 0);
    cnt = 7; step();
    chk("err_set", 32'(err), 1);
    stop = 1; step();
    step();
    chk("err_sticky", 32'(err), 1);
    rd(0, 5, "status_frozen_err");
    clear = 1; step();
    chk("err_cleared", 32'(err), 0);
    rd(0, 0, "status_after_clear");
    // freeze and resume
    cnt = 0; clear = 1; step();
    start = 1; step();
    repeat (3) step(1, 1, 0, 0);
    stop = 1; step();
    repeat (5) step(1, 1, 0, 0);
    start = 1; step();
    repeat (2) step(1, 1, 0, 0);
    step();
    rd(3, 5, "beats_in_resume");
    rd(0, 2, "status_resumed");
    chk("err_resume", 32'(err), 0);
    // saturation: the 4-bit twin tops out at 15
    cnt = 0; clear = 1; step();
    start = 1; step();
    repeat (14) step(1, 1, 0, 0);
    rd(3, 14, "beats_in_14", 1, 4'd14);
    repeat (3) step(1, 1, 0, 0);
    rd(3, 17, "beats_in_sat", 1, 4'd15);
    // reset while running and requesting: no ack, everything back to zero
    rd_req = 1; rd_addr = 3; ap_rst = 1;
    step();
    ap_rst = 0;
    chk("ack_dropped", 32'(rd_ack), 0);
    rd(0, 0, "status_after_rst");
    rd(3, 0, "beats_in_after_rst");
    chk("err_after_rst", 32'(err), 0);
    repeat (3) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
